// File: rtl/pe_array_2x2_if.sv
// Bus bundle between a job controller and the 2x2 systolic multiply array.
// The master drives the launch pulse and operands; the slave returns status and the held result matrix.
interface pe_array_2x2_if #(
  parameter int DATA_W = 8
);

  logic              start;
  logic [DATA_W-1:0] a11;
  logic [DATA_W-1:0] a12;
  logic [DATA_W-1:0] a21;
  logic [DATA_W-1:0] a22;
  logic [DATA_W-1:0] b11;
  logic [DATA_W-1:0] b12;
  logic [DATA_W-1:0] b21;
  logic [DATA_W-1:0] b22;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] c11_PE;
  logic [DATA_W-1:0] c12_PE;
  logic [DATA_W-1:0] c21_PE;
  logic [DATA_W-1:0] c22_PE;

  modport master (
    output start, a11, a12, a21, a22, b11, b12, b21, b22,
    input  busy, done, c11_PE, c12_PE, c21_PE, c22_PE
  );

  modport slave (
    input  start, a11, a12, a21, a22, b11, b12, b21, b22,
    output busy, done, c11_PE, c12_PE, c21_PE, c22_PE
  );

endinterface

// File: rtl/pe_array_2x2.sv
// 2x2 output-stationary systolic array computing C = A*B on 8-bit unsigned elements.
// Operands are captured on the start edge, streamed in skewed order over four steps,
// and the finished accumulators are copied to held output registers when the job ends.
// All arithmetic wraps modulo 2^DATA_W.
module pe_array_2x2 #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  pe_array_2x2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0] k;
  logic       capture;
  logic       step;
  logic       last_step;

  logic [DATA_W-1:0] a_cap [2][2];
  logic [DATA_W-1:0] b_cap [2][2];

  // Accumulator of each PE, indexed [row][col].
  logic [DATA_W-1:0] acc      [2][2];
  logic [DATA_W-1:0] acc_next [2][2];

  // Only the registers leaving column 0 (for a) and row 0 (for b) feed another PE;
  // whatever would leave the right or bottom edge of the array is dropped.
  logic [DATA_W-1:0] a_skew [2];
  logic [DATA_W-1:0] b_skew [2];

  logic [DATA_W-1:0] row_inj [2];
  logic [DATA_W-1:0] col_inj [2];
  logic [DATA_W-1:0] a_in    [2][2];
  logic [DATA_W-1:0] b_in    [2][2];

  logic [DATA_W-1:0] c_q [2][2];
  logic              busy_q;
  logic              done_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the per-cycle datapath controls.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (k == 2'd3) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Skewed edge injection: row i sees A[i][k-i], column j sees B[k-j][j], zero outside the window.
  always_comb begin
    row_inj[0] = '0;
    row_inj[1] = '0;
    col_inj[0] = '0;
    col_inj[1] = '0;
    case (k)
      2'd0: begin
        row_inj[0] = a_cap[0][0];
        col_inj[0] = b_cap[0][0];
      end
      2'd1: begin
        row_inj[0] = a_cap[0][1];
        row_inj[1] = a_cap[1][0];
        col_inj[0] = b_cap[1][0];
        col_inj[1] = b_cap[0][1];
      end
      2'd2: begin
        row_inj[1] = a_cap[1][1];
        col_inj[1] = b_cap[1][1];
      end
      default: begin
        row_inj[0] = '0;
      end
    endcase
  end

  // Operand routing into each PE and the multiply-accumulate result it would latch this step.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_in[i][0] = row_inj[i];
      a_in[i][1] = a_skew[i];
    end
    for (int j = 0; j < 2; j++) begin
      b_in[0][j] = col_inj[j];
      b_in[1][j] = b_skew[j];
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc_next[i][j] = acc[i][j] + a_in[i][j] * b_in[i][j];
      end
    end
  end

  // Operand capture, systolic stepping, and the result load on the final compute edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        a_skew[i] <= '0;
        b_skew[i] <= '0;
        for (int j = 0; j < 2; j++) begin
          a_cap[i][j] <= '0;
          b_cap[i][j] <= '0;
          acc[i][j]   <= '0;
          c_q[i][j]   <= '0;
        end
      end
    end else if (capture) begin
      k           <= 2'd0;
      a_cap[0][0] <= bus.a11;
      a_cap[0][1] <= bus.a12;
      a_cap[1][0] <= bus.a21;
      a_cap[1][1] <= bus.a22;
      b_cap[0][0] <= bus.b11;
      b_cap[0][1] <= bus.b12;
      b_cap[1][0] <= bus.b21;
      b_cap[1][1] <= bus.b22;
      for (int i = 0; i < 2; i++) begin
        a_skew[i] <= '0;
        b_skew[i] <= '0;
        for (int j = 0; j < 2; j++) begin
          acc[i][j] <= '0;
        end
      end
    end else if (step) begin
      k <= k + 2'd1;
      for (int i = 0; i < 2; i++) begin
        a_skew[i] <= a_in[i][0];
        b_skew[i] <= b_in[0][i];
        for (int j = 0; j < 2; j++) begin
          acc[i][j] <= acc_next[i][j];
          if (last_step) begin
            c_q[i][j] <= acc_next[i][j];
          end
        end
      end
    end
  end

  // Status flags are registered decodes of the state being entered, so they track state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.c11_PE = c_q[0][0];
  assign bus.c12_PE = c_q[0][1];
  assign bus.c21_PE = c_q[1][0];
  assign bus.c22_PE = c_q[1][1];

endmodule

// File: tb/tb_pe_array_2x2.sv
// Self-checking bench for pe_array_2x2: a scoreboard queue holds the expected C for every
// launched job and is drained whenever the array raises done.
module tb_pe_array_2x2;

  logic clk = 1'b0;
  logic reset;

  pe_array_2x2_if #(.DATA_W(8)) bus ();

  pe_array_2x2 #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Expected result matrices packed as {c11, c12, c21, c22}.
  logic [31:0] sb [$];

  // Free-running clock.
  always #5 clk = ~clk;

  // Plain 2x2 matrix product with 8-bit wrap; operands packed as {x11, x12, x21, x22}.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic [7:0] c11, c12, c21, c22;
    a11 = a[31:24]; a12 = a[23:16]; a21 = a[15:8]; a22 = a[7:0];
    b11 = b[31:24]; b12 = b[23:16]; b21 = b[15:8]; b22 = b[7:0];
    c11 = a11 * b11 + a12 * b21;
    c12 = a11 * b12 + a12 * b22;
    c21 = a21 * b11 + a22 * b21;
    c22 = a21 * b12 + a22 * b22;
    return {c11, c12, c21, c22};
  endfunction

  function automatic logic [31:0] get_c();
    return {bus.c11_PE, bus.c12_PE, bus.c21_PE, bus.c22_PE};
  endfunction

  function automatic logic [31:0] pop_exp();
    if (sb.size() == 0) return 32'hxxxxxxxx;
    return sb.pop_front();
  endfunction

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    bus.a11 = a[31:24]; bus.a12 = a[23:16]; bus.a21 = a[15:8]; bus.a22 = a[7:0];
    bus.b11 = b[31:24]; bus.b12 = b[23:16]; bus.b21 = b[15:8]; bus.b22 = b[7:0];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start with the given operands; returns in cycle 1 of the job.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    set_ops(a, b);
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    next_cycle();
    bus.start = 1'b0;
  endtask

  // Step until done rises or the cycle budget runs out; cyc is the job cycle at exit.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      next_cycle();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    set_ops(32'h0, 32'h0);
    next_cycle();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    vectors++;
    if (get_c() !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_c got %h want 00000000", get_c()); end
    reset = 1'b0;
    next_cycle();
    next_cycle();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] exp;
    applyStimulus({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy got %b want 1", bus.busy); end
    wait_done(cyc);
    vectors++;
    if (cyc != 5) begin miscompares++; $display("[TB] FAIL basic_latency got %0d want 5", cyc); end
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL basic_c got %h want %h", get_c(), exp); end
    vectors++;
    if (get_c() !== {8'd19, 8'd22, 8'd43, 8'd50}) begin
      miscompares++; $display("[TB] FAIL basic_c_literal got %h want 13162b32", get_c());
    end
    next_cycle();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_after_done got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
    set_ops(32'hdeadbeef, 32'h12345678);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      vectors++;
      if (get_c() !== exp || bus.done !== 1'b0) begin
        miscompares++; $display("[TB] FAIL basic_hold[%0d] got c=%h done=%b want c=%h done=0", i, get_c(), bus.done, exp);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [31:0] exp;
    applyStimulus({4{8'd15}}, {4{8'd15}});
    wait_done(cyc);
    vectors++;
    if (cyc != 5) begin miscompares++; $display("[TB] FAIL wrap15_latency got %0d want 5", cyc); end
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL wrap15_c got %h want %h", get_c(), exp); end
    next_cycle();
    applyStimulus({4{8'd16}}, {4{8'd16}});
    wait_done(cyc);
    vectors++;
    if (cyc != 5) begin miscompares++; $display("[TB] FAIL wrap16_latency got %0d want 5", cyc); end
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL wrap16_c got %h want %h", get_c(), exp); end
    next_cycle();
  endtask

  task automatic test_identity_zero();
    int cyc;
    logic [31:0] exp;
    logic [31:0] prev;
    applyStimulus({8'd1, 8'd0, 8'd0, 8'd1}, {8'd9, 8'd8, 8'd7, 8'd6});
    wait_done(cyc);
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL identity_c got %h want %h", get_c(), exp); end
    prev = exp;
    next_cycle();
    applyStimulus(32'h0, {8'd9, 8'd8, 8'd7, 8'd6});
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (get_c() !== prev) begin
        miscompares++; $display("[TB] FAIL zero_hold_cycle%0d got %h want %h", i, get_c(), prev);
      end
      next_cycle();
    end
    vectors++;
    if (bus.done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done got %b want 1", bus.done); end
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL zero_c got %h want %h", get_c(), exp); end
    next_cycle();
  endtask

  task automatic test_start_while_busy();
    logic [31:0] a0, b0, a1, b1, exp;
    int first_dones;
    int first_cyc;
    int second_cyc;
    a0 = {8'd2, 8'd3, 8'd4, 8'd5};
    b0 = {8'd6, 8'd7, 8'd8, 8'd9};
    a1 = {8'd10, 8'd11, 8'd12, 8'd13};
    b1 = {8'd1, 8'd2, 8'd3, 8'd4};
    first_dones = 0;
    first_cyc   = -1;
    second_cyc  = -1;
    applyStimulus(a0, b0);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (bus.done === 1'b1) begin
        if (cyc <= 10) begin
          first_dones++;
          first_cyc = cyc;
        end else begin
          second_cyc = cyc;
        end
        exp = pop_exp();
        vectors++;
        if (get_c() !== exp) begin
          miscompares++; $display("[TB] FAIL busy_start_c_cycle%0d got %h want %h", cyc, get_c(), exp);
        end
      end
      if (cyc == 1) set_ops(a1, b1);
      if (cyc == 2) bus.start = 1'b1;
      if (cyc == 3) bus.start = 1'b0;
      if (cyc == 5) bus.start = 1'b1;
      if (cyc == 6) sb.push_back(model(a1, b1));
      if (cyc == 7) bus.start = 1'b0;
      if (cyc < 11) next_cycle();
    end
    vectors++;
    if (first_dones != 1) begin miscompares++; $display("[TB] FAIL busy_start_done_count got %0d want 1", first_dones); end
    vectors++;
    if (first_cyc != 5) begin miscompares++; $display("[TB] FAIL busy_start_first_done got %0d want 5", first_cyc); end
    vectors++;
    if (second_cyc != 11) begin miscompares++; $display("[TB] FAIL busy_start_second_done got %0d want 11", second_cyc); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int dones;
    logic [31:0] exp;
    applyStimulus({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
    wait_done(cyc);
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL rst_prior_c got %h want %h", get_c(), exp); end
    next_cycle();
    applyStimulus({8'd3, 8'd1, 8'd4, 8'd1}, {8'd5, 8'd9, 8'd2, 8'd6});
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    vectors++;
    if (get_c() !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_c got %h want 00000000", get_c()); end
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_mid_flags got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    sb.delete();
    next_cycle();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("[TB] FAIL rst_no_done got %0d active cycles want 0", dones); end
    applyStimulus({8'd3, 8'd1, 8'd4, 8'd1}, {8'd5, 8'd9, 8'd2, 8'd6});
    wait_done(cyc);
    vectors++;
    if (cyc != 5) begin miscompares++; $display("[TB] FAIL rst_restart_latency got %0d want 5", cyc); end
    exp = pop_exp();
    vectors++;
    if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL rst_restart_c got %h want %h", get_c(), exp); end
    next_cycle();
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] a, b, exp;
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      b = $urandom;
      applyStimulus(a, b);
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 20) begin
        set_ops($urandom, $urandom);
        next_cycle();
        cyc++;
      end
      vectors++;
      if (cyc != 5) begin miscompares++; $display("[TB] FAIL rand%0d_latency got %0d want 5", n, cyc); end
      exp = pop_exp();
      vectors++;
      if (get_c() !== exp) begin miscompares++; $display("[TB] FAIL rand%0d_c got %h want %h", n, get_c(), exp); end
      next_cycle();
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_identity_zero();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pe_array_2x2.md
# pe_array_2x2

2x2 output-stationary systolic multiply array computing C = A·B for two 2x2 matrices of 8-bit unsigned elements. Sits directly upstream of the result-display stage and drives its c11_PE..c22_PE inputs. Results are held stable from completion until the next completed job. A controller launches each job with a one-cycle start pulse and observes busy/done.

## Interface
- DATA_W, 8, element, product and accumulator width (all arithmetic modulo 2^DATA_W)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- a11, a12, a21, a22  in  DATA_W  matrix A elements (row, column)
- b11, b12, b21, b22  in  DATA_W  matrix B elements
- busy  out  1  high in COMPUTE and DONE
- done  out  1  one-cycle pulse in DONE
- c11_PE, c12_PE, c21_PE, c22_PE  out  DATA_W  result matrix C, registered, held

## Operation
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- States: IDLE, COMPUTE, DONE. Step counter k is 2 bits.
- IDLE, start=1 at an edge:
  - capture all eight operands into internal registers
  - clear the four accumulators and all skew/propagation registers
  - set k=0 and go to COMPUTE
- IDLE, start=0: stay in IDLE. Outputs are unchanged.
- COMPUTE, each edge:
  - every PE(i,j) (0-based) adds a_in·b_in to its accumulator
  - k increments
  - after the k=3 edge, go to DONE
- Injection at step k:
  - row i gets A[i][k-i] when 0 ≤ k-i ≤ 1, else 0
  - column j gets B[k-j][j] when 0 ≤ k-j ≤ 1, else 0
- Propagation:
  - a moves right through one register per PE
  - b moves down through one register per PE
  - PE(i,j) therefore multiplies A[i][k-i-j]·B[k-i-j][j]
  - out-of-range terms are zero
- Load to outputs: on the same edge that leaves COMPUTE, the accumulator values, including the k=3 contribution, are written to the c*_PE registers.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Arithmetic: an 8x8 product truncated to DATA_W bits, added modulo 2^DATA_W. No saturation and no overflow flag.
- start while busy (COMPUTE or DONE): ignored. It is not queued.
- Operand inputs may change at any time after the capture edge. The computation uses only the captured values.
- Outputs change only on the COMPUTE→DONE edge and on reset.

## Timing
- Reset values:
  - state=IDLE, k=0
  - busy=0, done=0
  - c11_PE, c12_PE, c21_PE, c22_PE = 0
  - accumulators and skew registers = 0
- Cycle numbering, with start=1 in cycle 0 (IDLE):
  - cycles 1–4: COMPUTE k=0..3, busy=1
  - cycle 5: DONE, busy=1, done=1, new C visible on c*_PE
  - cycle 6: IDLE, busy=0; start is accepted again in this cycle
- Latency: start to done is 5 cycles. Back-to-back jobs have a throughput of one job per 6 cycles.
- Reset asserted mid-COMPUTE or in DONE:
  - immediate return to the reset values, including clearing the outputs
  - no done pulse
  - after release, the block waits in IDLE for a fresh start
- busy and done are registered decodes of state; there is no combinational path from start.

## Test plan
- Basic product:
  - stimulus: A=[1 2;3 4], B=[5 6;7 8], start pulse
  - required: done in cycle 5
  - required: c11_PE=19, c12_PE=22, c21_PE=43, c22_PE=50
  - required: values held through 20 idle cycles
- Wrap-around:
  - A all 15, B all 15: every c = 450 mod 256 = 194
  - A all 16, B all 16: every c = 0
- Identity and zero:
  - A=I, B=[9 8;7 6]: C=[9 8;7 6]
  - next job with A all 0: C all 0, replacing the previous result only at the new done
- start while busy:
  - stimulus: start pulses in cycles 2 and 5, operand inputs changed at cycle 1
  - required: exactly one done
  - required: result matches the operands captured in cycle 0
  - required: a start in cycle 6 launches a second job whose done lands in cycle 11
- Reset mid-operation:
  - stimulus: reset pulse in cycle 3 after a completed prior job with C=[19 22;43 50]
  - required: outputs go to 0 immediately, busy=0, no done
  - required: a new start then produces a correct result
- Operand isolation:
  - stimulus: operands randomized every cycle during COMPUTE
  - required: result equals the product of the values captured on the start edge
  - run over 200 random jobs against a modulo-256 reference model
